// File: rtl/seven_seg_pkg.sv
// Shared definitions for the three-digit seven-segment scanner.
//   slot_e      : which digit slot is currently being driven
//   bcd3_t      : hundreds/tens/ones BCD triple
//   SEG_BLANK   : all segments off (active-low)
//   SEG_DASH    : middle segment only, shown for non-BCD codes
//   AN_OFF      : all anodes off (active-low)
package seven_seg_pkg;

    typedef enum logic [1:0] {
        SLOT_ONES = 2'd0,
        SLOT_TENS = 2'd1,
        SLOT_HUND = 2'd2
    } slot_e;

    typedef struct packed {
        logic [3:0] hund;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd3_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [2:0] AN_OFF    = 3'b111;

    // Scan order ones -> tens -> hundreds -> ones.
    function automatic slot_e slot_next(input slot_e s);
        case (s)
            SLOT_ONES: slot_next = SLOT_TENS;
            SLOT_TENS: slot_next = SLOT_HUND;
            default:   slot_next = SLOT_ONES;
        endcase
    endfunction

    // Active-low anode pattern {hundreds,tens,ones} for a slot.
    function automatic logic [2:0] slot_anode(input slot_e s);
        case (s)
            SLOT_ONES: slot_anode = 3'b110;
            SLOT_TENS: slot_anode = 3'b101;
            SLOT_HUND: slot_anode = 3'b011;
            default:   slot_anode = AN_OFF;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
//   i_bcd   [3:0] : digit code; 10-15 decode to a dash
//   i_blank       : force all segments off
//   o_seg   [6:0] : active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_bcd)
                4'd0:    o_seg = 7'h40;
                4'd1:    o_seg = 7'h79;
                4'd2:    o_seg = 7'h24;
                4'd3:    o_seg = 7'h30;
                4'd4:    o_seg = 7'h19;
                4'd5:    o_seg = 7'h12;
                4'd6:    o_seg = 7'h02;
                4'd7:    o_seg = 7'h78;
                4'd8:    o_seg = 7'h00;
                4'd9:    o_seg = 7'h10;
                default: o_seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Three-digit multiplexed seven-segment scanner with ghosting guard.
// Each digit slot lasts REFRESH_DIV cycles; the first GUARD_CYCLES of a slot
// keep every anode off. New digits are staged in a pending register and only
// take effect at the frame boundary, so a frame never shows mixed values.
// Optional build macro SEVEN_SEG_LZB_EN enables leading-zero blanking.
//   clk            : clock, rising edge
//   rst_n          : synchronous active-low reset
//   hundreds [3:0] : BCD hundreds digit
//   tens     [3:0] : BCD tens digit
//   ones     [3:0] : BCD ones digit
//   digits_valid   : one-cycle strobe qualifying the three digits
//   seg      [6:0] : active-low segments {g,f,e,d,c,b,a}, registered
//   an       [2:0] : active-low anodes {hundreds,tens,ones}, registered
//   frame_done     : pulse on the last cycle of the hundreds slot
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       digits_valid,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_done
);

    localparam int            CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_V = CW'(GUARD_CYCLES);

    logic [CW-1:0] r_cnt;
    slot_e         r_slot;
    bcd3_t         r_disp;
    bcd3_t         r_pend;
    logic          r_pend_vld;

    bcd3_t         w_in;
    logic          w_cnt_last;
    logic [CW-1:0] w_cnt_nxt;
    slot_e         w_slot_nxt;
    logic          w_boundary;
    bcd3_t         w_disp_nxt;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [6:0]    w_dec;
    logic          w_guard;
    logic [6:0]    w_seg_nxt;
    logic [2:0]    w_an_nxt;
    logic          w_fd_nxt;

    assign w_in       = {hundreds, tens, ones};
    assign w_cnt_last = (r_cnt == CNT_MAX);
    assign w_cnt_nxt  = w_cnt_last ? '0 : r_cnt + CW'(1);
    assign w_slot_nxt = w_cnt_last ? slot_next(r_slot) : r_slot;
    // Edge that enters ones slot cycle 0.
    assign w_boundary = w_cnt_last && (r_slot == SLOT_HUND);

    // A strobe on the boundary cycle bypasses pending and is newer than it.
    always_comb begin
        w_disp_nxt = r_disp;
        if (w_boundary) begin
            if (digits_valid)    w_disp_nxt = w_in;
            else if (r_pend_vld) w_disp_nxt = r_pend;
        end
    end

    // Outputs are derived from next-state values so they land on the same
    // edge as the counter/slot they describe.
    always_comb begin
        w_digit = w_disp_nxt.ones;
        w_blank = 1'b0;
        case (w_slot_nxt)
            SLOT_TENS: w_digit = w_disp_nxt.tens;
            SLOT_HUND: w_digit = w_disp_nxt.hund;
            default:   w_digit = w_disp_nxt.ones;
        endcase
`ifdef SEVEN_SEG_LZB_EN
        case (w_slot_nxt)
            SLOT_HUND: w_blank = (w_disp_nxt.hund == 4'd0);
            SLOT_TENS: w_blank = (w_disp_nxt.hund == 4'd0) && (w_disp_nxt.tens == 4'd0);
            default:   w_blank = 1'b0;
        endcase
`endif
    end

    bcd_to_seg7 u_dec (
        .i_bcd   (w_digit),
        .i_blank (w_blank),
        .o_seg   (w_dec)
    );

    assign w_guard   = (w_cnt_nxt < GUARD_V);
    assign w_seg_nxt = w_guard ? SEG_BLANK : w_dec;
    assign w_an_nxt  = w_guard ? AN_OFF : slot_anode(w_slot_nxt);
    assign w_fd_nxt  = (w_slot_nxt == SLOT_HUND) && (w_cnt_nxt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_slot     <= SLOT_ONES;
            r_disp     <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            seg        <= SEG_BLANK;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_slot     <= w_slot_nxt;
            r_disp     <= w_disp_nxt;
            seg        <= w_seg_nxt;
            an         <= w_an_nxt;
            frame_done <= w_fd_nxt;
            if (w_boundary) begin
                r_pend_vld <= 1'b0;
            end else if (digits_valid) begin
                r_pend     <= w_in;
                r_pend_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan with REFRESH_DIV=8, GUARD_CYCLES=2.
// The bench tracks its own frame position from reset and holds the expected
// per-slot segment patterns in a queue tagged with the frame they apply to.
module tb_seven_seg_scan;

    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int FRAME = 3 * DIV;

    typedef struct {
        logic [6:0] sh;
        logic [6:0] st;
        logic [6:0] so;
    } disp_exp_t;

    typedef struct {
        int        frame;
        disp_exp_t d;
    } sb_t;

    typedef struct {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        disp_exp_t  e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] hundreds, tens, ones;
    logic       digits_valid;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_done;

    int        checks = 0;
    int        errors = 0;
    int        pos = 0;
    logic      rst_seen = 1'b0;
    logic      mon_en = 1'b0;
    sb_t       q[$];
    disp_exp_t exp_disp;
    disp_exp_t rst_exp;
    vec_t      vecs[6];

    int         m_p, m_fr, m_slot, m_c;
    logic [2:0] m_an;
    logic [6:0] m_seg;
    logic       m_fd;

    seven_seg_scan #(.REFRESH_DIV(DIV), .GUARD_CYCLES(GUARD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hundreds     (hundreds),
        .tens         (tens),
        .ones         (ones),
        .digits_valid (digits_valid),
        .seg          (seg),
        .an           (an),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // pos = number of edges since the last reset edge; 0 is ones slot cycle 0.
    always @(posedge clk) begin
        if (!rst_n) begin
            pos      <= 0;
            rst_seen <= 1'b1;
        end else begin
            pos      <= pos + 1;
            rst_seen <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_seen) begin
                checks++;
                if ({an, seg, frame_done} !== {3'b111, 7'h7F, 1'b0}) begin
                    errors++;
                    $display("FAIL reset: an=%b seg=%h fd=%b, expected an=111 seg=7f fd=0",
                             an, seg, frame_done);
                end
                q.delete();
                exp_disp = rst_exp;
            end else begin
                m_p  = pos % FRAME;
                m_fr = pos / FRAME;
                if (m_p == 0) begin
                    while (q.size() > 0 && q[0].frame <= m_fr) begin
                        exp_disp = q[0].d;
                        void'(q.pop_front());
                    end
                end
                m_slot = m_p / DIV;
                m_c    = m_p % DIV;
                m_fd   = (m_p == FRAME - 1);
                if (m_c < GUARD) begin
                    m_an  = 3'b111;
                    m_seg = 7'h7F;
                end else if (m_slot == 0) begin
                    m_an  = 3'b110;
                    m_seg = exp_disp.so;
                end else if (m_slot == 1) begin
                    m_an  = 3'b101;
                    m_seg = exp_disp.st;
                end else begin
                    m_an  = 3'b011;
                    m_seg = exp_disp.sh;
                end
                checks++;
                if ({an, seg, frame_done} !== {m_an, m_seg, m_fd}) begin
                    errors++;
                    $display("FAIL scan pos=%0d slot=%0d cyc=%0d: an=%b seg=%h fd=%b, expected an=%b seg=%h fd=%b",
                             pos, m_slot, m_c, an, seg, frame_done, m_an, m_seg, m_fd);
                end
            end
        end
    end

    task automatic wait_p(input int tp);
        for (int n = 0; n < 2 * FRAME + 2; n++) begin
            if (pos % FRAME == tp) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL wait_p: position %0d not reached, at pos=%0d", tp, pos);
    endtask

    // Drive a strobe in the current cycle; it takes effect in the frame that
    // starts at the next boundary at or after the sampling edge.
    task automatic strobe(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                          input disp_exp_t e);
        sb_t s;
        hundreds     = h;
        tens         = t;
        ones         = o;
        digits_valid = 1'b1;
        s.frame = (pos + FRAME) / FRAME;
        s.d     = e;
        q.push_back(s);
        @(negedge clk);
        digits_valid = 1'b0;
    endtask

    function automatic disp_exp_t mk(input logic [6:0] sh, input logic [6:0] st,
                                     input logic [6:0] so);
        disp_exp_t d;
        d.sh = sh;
        d.st = st;
        d.so = so;
        return d;
    endfunction

    initial begin
`ifdef SEVEN_SEG_LZB_EN
        rst_exp = mk(7'h7F, 7'h7F, 7'h40);
        vecs[2] = '{h: 4'd0, t: 4'd0, o: 4'd7, e: mk(7'h7F, 7'h7F, 7'h78)};
        vecs[4] = '{h: 4'd0, t: 4'd5, o: 4'd0, e: mk(7'h7F, 7'h12, 7'h40)};
`else
        rst_exp = mk(7'h40, 7'h40, 7'h40);
        vecs[2] = '{h: 4'd0, t: 4'd0, o: 4'd7, e: mk(7'h40, 7'h40, 7'h78)};
        vecs[4] = '{h: 4'd0, t: 4'd5, o: 4'd0, e: mk(7'h40, 7'h12, 7'h40)};
`endif
        vecs[0] = '{h: 4'd1,  t: 4'd2,  o: 4'd3, e: mk(7'h79, 7'h24, 7'h30)};
        vecs[1] = '{h: 4'd4,  t: 4'd5,  o: 4'd6, e: mk(7'h19, 7'h12, 7'h02)};
        vecs[3] = '{h: 4'd8,  t: 4'd12, o: 4'd9, e: mk(7'h00, 7'h3F, 7'h10)};
        vecs[5] = '{h: 4'd15, t: 4'd0,  o: 4'd0, e: mk(7'h3F, 7'h40, 7'h40)};
        exp_disp = rst_exp;

        rst_n        = 1'b0;
        hundreds     = 4'd0;
        tens         = 4'd0;
        ones         = 4'd0;
        digits_valid = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // One frame of default 0/0/0, then each vector strobed mid-tens slot.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wait_p(12);
            strobe(vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].e);
        end
        wait_p(FRAME - 1);
        @(negedge clk);
        wait_p(FRAME - 1);

        // Two strobes in one frame: only the later one is shown.
        @(negedge clk);
        wait_p(5);
        strobe(4'd9, 4'd8, 4'd7, mk(7'h10, 7'h00, 7'h78));
        wait_p(14);
        strobe(4'd2, 4'd4, 4'd6, mk(7'h24, 7'h19, 7'h02));

        // Strobe on the boundary cycle appears in the frame starting next.
        wait_p(FRAME - 1);
        @(negedge clk);
        wait_p(FRAME - 1);
        strobe(4'd3, 4'd1, 4'd4, mk(7'h30, 7'h79, 7'h19));

        // Strobe on ones slot cycle 0 waits for the following frame.
        wait_p(0);
        strobe(4'd7, 4'd7, 4'd7, mk(7'h78, 7'h78, 7'h78));
        wait_p(FRAME - 1);
        @(negedge clk);
        wait_p(FRAME - 1);
        @(negedge clk);

        // Reset in the hundreds slot with a pending value: value is dropped.
        wait_p(18);
        strobe(4'd5, 4'd5, 4'd5, mk(7'h12, 7'h12, 7'h12));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FRAME + 4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
